// File: rtl/bus_uart_tx_pkg.sv
// Shared constants for the bus-attached UART transmitter: register offsets,
// STATUS bit positions and the serializer state encoding.
package bus_uart_tx_pkg;

  // Register select values, compared against addr_i[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // FIFO occupancy squeezed into the 4-bit STATUS level field
  function automatic logic [3:0] sat_level(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the serializer. count_o exists only when
// BUS_UART_TX_LEVEL_EN is defined.
module bus_uart_tx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o
`ifdef BUS_UART_TX_LEVEL_EN
  ,
  output logic [$clog2(Depth):0]   count_o
`endif
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == Depth[AW:0]);
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is still taken when a pop frees a slot this cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

`ifdef BUS_UART_TX_LEVEL_EN
  assign count_o = cnt_q;
`endif

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core req/gnt/rvalid data bus.
// Define BUS_UART_TX_LEVEL_EN to expose FIFO occupancy in STATUS[11:8].
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter int unsigned ClkDiv    = 217,
  parameter int unsigned FifoDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  localparam logic [15:0] DivRst = 16'(ClkDiv - 1);

  logic [1:0]  reg_sel;
  logic        wr_txdata, wr_status, wr_div;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
`ifdef BUS_UART_TX_LEVEL_EN
  logic [$clog2(FifoDepth):0] fifo_count;
`endif

  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status;

  tx_state_e   state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  logic        unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

  // Zero-wait-state responder: every request is granted in its own cycle
  assign gnt_o     = req_i;
  assign reg_sel   = addr_i[3:2];
  assign wr_txdata = req_i & we_i & (reg_sel == REG_TXDATA);
  assign wr_status = req_i & we_i & (reg_sel == REG_STATUS);
  assign wr_div    = req_i & we_i & (reg_sel == REG_DIV);
  assign fifo_push = wr_txdata & be_i[0];

  bus_uart_tx_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
`ifdef BUS_UART_TX_LEVEL_EN
    ,
    .count_o (fifo_count)
`endif
  );

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state_q != IDLE) | ~fifo_empty;
    status[ST_OVF]   = ovf_q;
`ifdef BUS_UART_TX_LEVEL_EN
    status[11:8]     = sat_level(32'(fifo_count));
`endif
  end

  // A dropped byte only counts as overflow if no pop frees a slot this cycle
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (wr_status && be_i[0] && wdata_i[ST_OVF]) ovf_d = 1'b0;
  end

  always_comb begin
    div_d = div_q;
    if (wr_div && be_i[0]) div_d[7:0]  = wdata_i[7:0];
    if (wr_div && be_i[1]) div_d[15:8] = wdata_i[15:8];
  end

  always_comb begin
    rdata_d = '0;
    if (req_i && !we_i) begin
      case (reg_sel)
        REG_STATUS: rdata_d = status;
        REG_DIV:    rdata_d = {16'h0000, div_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // Serializer: every bit period reloads from the live DIV, so DIV writes
  // land on the next bit boundary without disturbing the bit in flight.
  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_rdata;
          cnt_d    = div_q;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = div_q;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
        else         cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state to keep tx_o glitch-free
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      div_q    <= DivRst;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign tx_o     = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register vector table, hand-written
// timing sequences and a randomized run against a frame-timing model.
module tb_bus_uart_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, tx;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bus_uart_tx #(.ClkDiv(CLK_DIV), .FifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .tx_o(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus access starting just after a clock edge; returns the response data
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1 check("gnt follows req", gnt, 1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    check("rvalid after grant", rvalid, 1);
    rd = rdata;
  endtask

  // ---------------- serial line monitor ----------------
  bit        mon_en = 1'b0;
  bit        mon_busy = 1'b0;
  int        mon_p = CLK_DIV;
  logic [7:0] rx_q[$];
  int        rxs_q[$];

  initial begin : monitor
    int p, s;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        mon_busy = 1'b1; p = mon_p; s = cyc;
        repeat (p / 2) @(negedge clk);
        check("mon start bit", tx, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (p) @(negedge clk);
          b[k] = tx;
        end
        repeat (p) @(negedge clk);
        check("mon stop bit", tx, 1);
        rx_q.push_back(b);
        rxs_q.push_back(s);
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model for the random run ----------------
  int   P = CLK_DIV;
  int   mN[$], mS[$];
  logic [7:0] mB[$];
  bit   ovf_m = 1'b0;
  int   lastS = -100000;

  // A byte sits in the FIFO from the cycle after its push up to the cycle before its start bit
  function automatic int occ_at(int c);
    int n = 0;
    foreach (mN[k]) if (mN[k] < c && c < mS[k]) n++;
    return n;
  endfunction

  function automatic bit pop_at(int c);
    foreach (mS[k]) if (mS[k] - 1 == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit frame_at(int c);
    foreach (mS[k]) if (c >= mS[k] && c < mS[k] + 10 * P) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] status_model(int c);
    int o = occ_at(c);
    logic [31:0] s = '0;
    s[0] = (o == DEPTH);
    s[1] = (o == 0);
    s[2] = (o > 0) || frame_at(c);
    s[3] = ovf_m;
`ifdef BUS_UART_TX_LEVEL_EN
    s[11:8] = (o > 15) ? 4'hF : o[3:0];
`endif
    return s;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  function automatic void add(string n, logic w, logic [31:0] a, logic [31:0] d,
                              logic [3:0] b, logic [31:0] e);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.wdata = d; v.be = b; v.exp = e;
    vt.push_back(v);
  endfunction

  initial begin : main
    logic [31:0] rd;
    logic [7:0]  b1, b2;
    logic        exp_tx[$];
    int          n0, lows;
    bit          pend_v, pend_rd;
    logic [31:0] pend_exp;
    int          div_r;

    // ---- reset state ----
    repeat (3) @(posedge clk); #1;
    check("reset tx", tx, 1);
    check("reset rvalid", rvalid, 0);
    check("reset rdata", rdata, 0);
    check("reset gnt", gnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset tx", tx, 1);
    mon_en = 1'b1;
    bus(0, 32'h4, 0, 4'h0, rd); check("reset STATUS", rd, 32'h2);
    bus(0, 32'h8, 0, 4'h0, rd); check("reset DIV", rd, 32'h3);

    // ---- register table ----
    add("rd status",       0, 32'h4,    0,            4'h0, 32'h2);
    add("wr div 1234",     1, 32'h8,    32'h1234,     4'h3, 0);
    add("rd div 1234",     0, 32'h8,    0,            4'h0, 32'h1234);
    add("wr div hi byte",  1, 32'h8,    32'hFFFFAB00, 4'h2, 0);
    add("rd div AB34",     0, 32'h8,    0,            4'h0, 32'hAB34);
    add("wr div lo byte",  1, 32'h8,    32'hFFFFFF56, 4'h1, 0);
    add("rd div AB56",     0, 32'h8,    0,            4'h0, 32'hAB56);
    add("wr div upper be", 1, 32'h8,    32'hFFFFFFFF, 4'hC, 0);
    add("rd div unchanged",0, 32'h8,    0,            4'h0, 32'hAB56);
    add("wr txdata no be0",1, 32'h0,    32'h55,       4'hE, 0);
    add("rd status empty", 0, 32'h4,    0,            4'h0, 32'h2);
    add("rd txdata",       0, 32'h0,    0,            4'h0, 0);
    add("rd reserved",     0, 32'hC,    0,            4'h0, 0);
    add("wr reserved",     1, 32'hC,    32'hFFFFFFFF, 4'hF, 0);
    add("rd status after", 0, 32'h4,    0,            4'h0, 32'h2);
    add("rd div after",    0, 32'h8,    0,            4'h0, 32'hAB56);
    add("wr status ones",  1, 32'h4,    32'hFFFFFFFF, 4'hF, 0);
    add("rd status ro",    0, 32'h4,    0,            4'h0, 32'h2);
    add("wr div 3",        1, 32'h8,    32'h3,        4'h3, 0);
    add("rd div alias",    0, 32'h1008, 0,            4'h0, 32'h3);
    for (int i = 0; i < vt.size(); i++) begin
      bus(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd);
      if (!vt[i].we) check(vt[i].name, rd, vt[i].exp);
      @(posedge clk); #1;
      check("single rvalid", rvalid, 0);
    end
    check("tx idle after table", tx, 1);

    // ---- single frame 0xA5 ----
    rx_q.delete(); rxs_q.delete(); mon_p = 4;
    n0 = cyc;
    bus(1, 32'h0, 32'hA5, 4'h1, rd);
    check("A5 line before pop", tx, 1);
    b1 = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i / 4 == 0)      check("A5 start", tx, 0);
      else if (i / 4 == 9) check("A5 stop", tx, 1);
      else                 check("A5 data", tx, b1[i / 4 - 1]);
    end
    @(posedge clk); #1;
    bus(0, 32'h4, 0, 4'h0, rd); check("A5 STATUS after", rd, 32'h2);
    check("A5 rx count", rx_q.size(), 1);
    if (rx_q.size() > 0) begin
      check("A5 rx byte", rx_q[0], 8'hA5);
      check("A5 start cycle", rxs_q[0], n0 + 2);
    end

    // ---- ten back-to-back writes ----
    rx_q.delete(); rxs_q.delete();
    n0 = cyc;
    for (int i = 0; i < 10; i++) begin
      req = 1'b1; we = 1'b1; addr = 32'h0; wdata = i; be = 4'h1;
      @(posedge clk); #1;
      check("b2b rvalid", rvalid, 1);
    end
    req = 1'b0; we = 1'b0; be = '0;
    bus(0, 32'h4, 0, 4'h0, rd); check("b2b STATUS full+ovf", rd, 32'hD);
    bus(1, 32'h4, 32'h8, 4'h1, rd);
    bus(0, 32'h4, 0, 4'h0, rd); check("b2b STATUS ovf cleared", rd, 32'h5);
    while (cyc < n0 + 2 + 9 * 41 + 5) begin @(posedge clk); #1; end
    check("b2b rx count", rx_q.size(), 9);
    for (int k = 0; k < 9 && k < rx_q.size(); k++) begin
      check("b2b rx byte", rx_q[k], k);
      check("b2b start cycle", rxs_q[k], n0 + 2 + 41 * k);
    end
    bus(0, 32'h4, 0, 4'h0, rd); check("b2b STATUS drained", rd, 32'h2);

    // ---- DIV change mid-frame ----
    for (int k = 0; k < 200 && mon_busy; k++) @(posedge clk);
    #1 mon_en = 1'b0;
    b1 = 8'h3C; b2 = 8'hC3;
    repeat (4) exp_tx.push_back(1'b0);
    for (int k = 0; k < 4; k++) repeat (4) exp_tx.push_back(b1[k]);
    for (int k = 4; k < 8; k++) repeat (8) exp_tx.push_back(b1[k]);
    repeat (9) exp_tx.push_back(1'b1);
    repeat (8) exp_tx.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (8) exp_tx.push_back(b2[k]);
    repeat (12) exp_tx.push_back(1'b1);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = {24'h0, b1}; be = 4'h1;
    @(posedge clk); #1;
    wdata = {24'h0, b2};
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = '0;
    for (int t = 0; t < exp_tx.size(); t++) begin
      check("div7 waveform", tx, exp_tx[t]);
      if (t == 17) begin
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h7; be = 4'h3;
      end else begin
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      end
      @(posedge clk); #1;
    end
    bus(0, 32'h8, 0, 4'h0, rd); check("div7 DIV readback", rd, 32'h7);
    bus(1, 32'h8, 32'h3, 4'h3, rd);

    // ---- reset mid-frame ----
    bus(1, 32'h8, 32'h5, 4'h3, rd);
    n0 = cyc;
    for (int i = 0; i < 10; i++) begin
      req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h40 + i; be = 4'h1;
      @(posedge clk); #1;
    end
    req = 1'b0; we = 1'b0; be = '0;
    bus(0, 32'h4, 0, 4'h0, rd); check("pre-reset STATUS", rd, 32'hD);
    while (cyc < n0 + 22) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid-frame reset tx", tx, 1);
    check("mid-frame reset rvalid", rvalid, 0);
    bus(0, 32'h4, 0, 4'h0, rd); check("reset STATUS cleared", rd, 32'h2);
    bus(0, 32'h8, 0, 4'h0, rd); check("reset DIV restored", rd, 32'h3);
    lows = 0;
    repeat (100) begin @(posedge clk); #1; if (tx !== 1'b1) lows++; end
    check("no start after reset", lows, 0);

    // ---- randomized run against the model ----
    div_r = $urandom_range(1, 3);
    P = div_r + 1;
    bus(1, 32'h8, div_r, 4'h3, rd);
    mon_p = P; rx_q.delete(); rxs_q.delete(); mon_en = 1'b1;
    pend_v = 1'b1; pend_rd = 1'b0; pend_exp = '0;
    for (int i = 0; i < 600; i++) begin
      int c, r;
      logic [7:0] bb;
      bit set_ovf, clr_ovf;
      c = cyc;
      check("rnd rvalid", rvalid, pend_v);
      if (pend_rd) check("rnd rdata", rdata, pend_exp);
      r = $urandom_range(0, 99);
      set_ovf = 1'b0; clr_ovf = 1'b0;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      if (r < ((i < 300) ? 14 : 4)) begin
        bb = 8'($urandom);
        req = 1'b1; we = 1'b1; addr = 32'h0; wdata = {$urandom, bb}; wdata[31:8] = 24'($urandom); be = 4'h1;
        if (occ_at(c) < DEPTH || pop_at(c)) begin
          mN.push_back(c);
          mS.push_back((c + 2 > lastS + 10 * P + 1) ? c + 2 : lastS + 10 * P + 1);
          mB.push_back(bb);
          lastS = mS[mS.size() - 1];
        end else begin
          set_ovf = 1'b1;
        end
      end else if (r < 40) begin
        req = 1'b1; addr = 32'h4; pend_exp = status_model(c);
      end else if (r < 45) begin
        req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'h8; be = 4'h1; clr_ovf = 1'b1;
      end else if (r < 52) begin
        req = 1'b1; addr = 32'h8; pend_exp = div_r;
      end
      pend_v = req;
      pend_rd = req & ~we;
      if (set_ovf) ovf_m = 1'b1;
      if (clr_ovf) ovf_m = 1'b0;
      @(posedge clk); #1;
    end
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    check("rnd last rvalid", rvalid, pend_v);
    if (pend_rd) check("rnd last rdata", rdata, pend_exp);
    while (cyc < lastS + 10 * P + 4) begin @(posedge clk); #1; end
    check("rnd frame count", rx_q.size(), mB.size());
    for (int k = 0; k < mB.size() && k < rx_q.size(); k++) begin
      check("rnd rx byte", rx_q[k], mB[k]);
      check("rnd start cycle", rxs_q[k], mS[k]);
    end
    bus(0, 32'h4, 0, 4'h0, rd); check("rnd final STATUS", rd, status_model(cyc - 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
